// File: rtl/stream_scheduler_if.sv
// Handshake bundle between the stream scheduler and its sources, filter and sink.
// The master modport is the scheduler side; the slave modport is the environment side.
interface stream_scheduler_if #(
  parameter int DWIDTH         = 16,
  parameter int NR_STREAMS     = 4,
  parameter int NR_STREAMS_LOG = 2
);
  logic [NR_STREAMS-1:0]        src_valid;
  logic [NR_STREAMS*DWIDTH-1:0] src_data;
  logic [NR_STREAMS-1:0]        src_ready;
  logic                         flt_req_in;
  logic                         flt_ack_in;
  logic [DWIDTH-1:0]            flt_data_in;
  logic                         flt_req_out;
  logic                         flt_ack_out;
  logic [DWIDTH-1:0]            flt_data_out;
  logic                         snk_valid;
  logic [DWIDTH-1:0]            snk_data;
  logic [NR_STREAMS_LOG-1:0]    snk_stream;
  logic                         snk_ready;

  modport master (
    input  src_valid, src_data, flt_req_in, flt_req_out, flt_data_out, snk_ready,
    output src_ready, flt_ack_in, flt_data_in, flt_ack_out, snk_valid, snk_data, snk_stream
  );

  modport slave (
    output src_valid, src_data, flt_req_in, flt_req_out, flt_data_out, snk_ready,
    input  src_ready, flt_ack_in, flt_data_in, flt_ack_out, snk_valid, snk_data, snk_stream
  );
endinterface

// File: rtl/stream_scheduler.sv
// Feeds a shared multi-stream filter from per-stream sources in round-robin order and
// forwards each filter result to one sink tagged with its stream index.
module stream_scheduler #(
  parameter int DWIDTH         = 16,
  parameter int NR_STREAMS     = 4,
  parameter int NR_STREAMS_LOG = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  stream_scheduler_if.master        bus,
  output logic [NR_STREAMS_LOG-1:0] cur_stream,
  output logic [CNT_WIDTH-1:0]      underrun_cnt
);

  typedef enum logic [1:0] {IDLE, IN_ACK, OUT_ACK, SNK_HOLD} state_e;

  state_e                    state_q, state_d;
  logic [NR_STREAMS_LOG-1:0] cur_stream_q, cur_stream_d;
  logic                      in_pending_q, in_pending_d;
  logic [CNT_WIDTH-1:0]      underrun_cnt_q, underrun_cnt_d;
  logic [NR_STREAMS-1:0]     src_ready_q, src_ready_d;
  logic                      flt_ack_in_q, flt_ack_in_d;
  logic [DWIDTH-1:0]         flt_data_in_q, flt_data_in_d;
  logic                      flt_ack_out_q, flt_ack_out_d;
  logic                      snk_valid_q, snk_valid_d;
  logic [DWIDTH-1:0]         snk_data_q, snk_data_d;
  logic [NR_STREAMS_LOG-1:0] snk_stream_q, snk_stream_d;

  logic              cur_valid;
  logic [DWIDTH-1:0] cur_sample;

  // Only the current stream's source is ever looked at, so no reordering is possible.
  always_comb begin
    cur_sample = '0;
    for (int i = 0; i < NR_STREAMS; i++) begin
      if (cur_stream_q == NR_STREAMS_LOG'(i)) cur_sample = bus.src_data[i*DWIDTH +: DWIDTH];
    end
  end

  assign cur_valid = bus.src_valid[cur_stream_q];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    cur_stream_d   = cur_stream_q;
    in_pending_d   = in_pending_q;
    underrun_cnt_d = underrun_cnt_q;
    src_ready_d    = '0;
    flt_ack_in_d   = 1'b0;
    flt_data_in_d  = '0;
    flt_ack_out_d  = 1'b0;
    snk_valid_d    = snk_valid_q;
    snk_data_d     = snk_data_q;
    snk_stream_d   = snk_stream_q;

    unique case (state_q)
      IDLE: begin
        // Output side wins; an input request waits while a sample is already in the filter.
        if (bus.flt_req_out && !snk_valid_q) begin
          state_d       = OUT_ACK;
          flt_ack_out_d = 1'b1;
        end else if (!in_pending_q && bus.flt_req_in) begin
          if (cur_valid) begin
            state_d       = IN_ACK;
            flt_ack_in_d  = 1'b1;
            flt_data_in_d = cur_sample;
            src_ready_d   = NR_STREAMS'(1) << cur_stream_q;
          end else if (underrun_cnt_q != '1) begin
            underrun_cnt_d = underrun_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      IN_ACK: begin
        in_pending_d = 1'b1;
        state_d      = IDLE;
      end
      OUT_ACK: begin
        snk_valid_d  = 1'b1;
        snk_data_d   = bus.flt_data_out;
        snk_stream_d = cur_stream_q;
        in_pending_d = 1'b0;
        cur_stream_d = cur_stream_q + NR_STREAMS_LOG'(1);
        state_d      = SNK_HOLD;
      end
      SNK_HOLD: begin
        if (bus.snk_ready) begin
          snk_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_stream_q   <= '0;
      in_pending_q   <= 1'b0;
      underrun_cnt_q <= '0;
      src_ready_q    <= '0;
      flt_ack_in_q   <= 1'b0;
      flt_data_in_q  <= '0;
      flt_ack_out_q  <= 1'b0;
      snk_valid_q    <= 1'b0;
      snk_data_q     <= '0;
      snk_stream_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q        <= state_d;
      cur_stream_q   <= cur_stream_d;
      in_pending_q   <= in_pending_d;
      underrun_cnt_q <= underrun_cnt_d;
      src_ready_q    <= src_ready_d;
      flt_ack_in_q   <= flt_ack_in_d;
      flt_data_in_q  <= flt_data_in_d;
      flt_ack_out_q  <= flt_ack_out_d;
      snk_valid_q    <= snk_valid_d;
      snk_data_q     <= snk_data_d;
      snk_stream_q   <= snk_stream_d;
    end
  end

  assign bus.src_ready   = src_ready_q;
  assign bus.flt_ack_in  = flt_ack_in_q;
  assign bus.flt_data_in = flt_data_in_q;
  assign bus.flt_ack_out = flt_ack_out_q;
  assign bus.snk_valid   = snk_valid_q;
  assign bus.snk_data    = snk_data_q;
  assign bus.snk_stream  = snk_stream_q;
  assign cur_stream      = cur_stream_q;
  assign underrun_cnt    = underrun_cnt_q;

endmodule

// File: tb/tb_stream_scheduler.sv
// Directed bench for stream_scheduler: each task drives one scenario and compares
// the DUT against hand-computed values one time unit after the rising edge.
module tb_stream_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cur_stream;
  logic [15:0] underrun_cnt;

  int errors = 0;
  int checks = 0;

  stream_scheduler_if #(.DWIDTH(16), .NR_STREAMS(4), .NR_STREAMS_LOG(2)) bus ();

  stream_scheduler #(
    .DWIDTH(16), .NR_STREAMS(4), .NR_STREAMS_LOG(2), .CNT_WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .cur_stream   (cur_stream),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.src_valid    = '0;
    bus.src_data     = '0;
    bus.flt_req_in   = 1'b0;
    bus.flt_req_out  = 1'b0;
    bus.flt_data_out = '0;
    bus.snk_ready    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.src_ready, bus.flt_ack_in, bus.flt_data_in, bus.flt_ack_out,
         bus.snk_valid, bus.snk_data, bus.snk_stream, cur_stream, underrun_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack_in=%b ack_out=%b snk_valid=%b cur=%0d cnt=%0d, want all 0",
               bus.flt_ack_in, bus.flt_ack_out, bus.snk_valid, cur_stream, underrun_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.src_ready, bus.flt_ack_in, bus.flt_ack_out, bus.snk_valid} !== 7'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got src_ready=%b ack_in=%b ack_out=%b snk_valid=%b, want 0",
                 i, bus.src_ready, bus.flt_ack_in, bus.flt_ack_out, bus.snk_valid);
      end
    end
  endtask

  task automatic test_input();
    bus.src_valid         = 4'b0001;
    bus.src_data[15:0]    = 16'h1234;
    bus.flt_req_in        = 1'b1;
    tick();
    checks++;
    if (bus.flt_ack_in !== 1'b1 || bus.flt_data_in !== 16'h1234 || bus.src_ready !== 4'b0001) begin
      errors++;
      $display("FAIL input_ack: got ack=%b data=%h ready=%b, want 1 1234 0001",
               bus.flt_ack_in, bus.flt_data_in, bus.src_ready);
    end
    bus.flt_req_in = 1'b0;
    bus.src_valid  = 4'b0000;
    tick();
    checks++;
    if (bus.flt_ack_in !== 1'b0 || bus.src_ready !== 4'b0000) begin
      errors++;
      $display("FAIL input_pulse: got ack=%b ready=%b, want 0 0000", bus.flt_ack_in, bus.src_ready);
    end
  endtask

  // One output transfer from IDLE with snk_ready already high.
  task automatic do_output(input logic [15:0] data, input logic [1:0] exp_stream);
    bus.flt_req_out  = 1'b1;
    bus.flt_data_out = data;
    bus.snk_ready    = 1'b1;
    tick();
    checks++;
    if (bus.flt_ack_out !== 1'b1 || bus.snk_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_ack: got ack_out=%b snk_valid=%b, want 1 0", bus.flt_ack_out, bus.snk_valid);
    end
    bus.flt_req_out = 1'b0;
    tick();
    checks++;
    if (bus.flt_ack_out !== 1'b0 || bus.snk_valid !== 1'b1 || bus.snk_data !== data ||
        bus.snk_stream !== exp_stream || cur_stream !== exp_stream + 2'd1) begin
      errors++;
      $display("FAIL out_snk: got ack_out=%b valid=%b data=%h stream=%0d cur=%0d, want 0 1 %h %0d %0d",
               bus.flt_ack_out, bus.snk_valid, bus.snk_data, bus.snk_stream, cur_stream,
               data, exp_stream, exp_stream + 2'd1);
    end
    tick();
    checks++;
    if (bus.snk_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_release: got snk_valid=%b, want 0", bus.snk_valid);
    end
  endtask

  task automatic test_output();
    do_output(16'hABCD, 2'd0);
  endtask

  task automatic test_wrap();
    do_output(16'h1001, 2'd1);
    do_output(16'h1002, 2'd2);
    do_output(16'h1003, 2'd3);
    do_output(16'h1004, 2'd0);
  endtask

  task automatic test_underrun();
    // Stream 1 is current and empty; other sources are valid but must not be taken.
    bus.src_valid  = 4'b1101;
    bus.flt_req_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.flt_ack_in !== 1'b0 || bus.src_ready !== 4'b0000) begin
        errors++;
        $display("FAIL underrun_noack[%0d]: got ack=%b ready=%b, want 0 0000",
                 i, bus.flt_ack_in, bus.src_ready);
      end
    end
    checks++;
    if (underrun_cnt !== 16'd5) begin
      errors++;
      $display("FAIL underrun_cnt5: got %0d, want 5", underrun_cnt);
    end
    for (int i = 0; i < 16'hFFFE - 5; i++) tick();
    checks++;
    if (underrun_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL underrun_fffe: got %h, want fffe", underrun_cnt);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (underrun_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL underrun_sat: got %h, want ffff", underrun_cnt);
    end
    bus.src_valid       = 4'b1111;
    bus.src_data[31:16] = 16'h5678;
    tick();
    checks++;
    if (bus.flt_ack_in !== 1'b1 || bus.flt_data_in !== 16'h5678 || bus.src_ready !== 4'b0010 ||
        underrun_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL underrun_recover: got ack=%b data=%h ready=%b cnt=%h, want 1 5678 0010 ffff",
               bus.flt_ack_in, bus.flt_data_in, bus.src_ready, underrun_cnt);
    end
    bus.flt_req_in = 1'b0;
    bus.src_valid  = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    bus.snk_ready    = 1'b0;
    bus.flt_req_out  = 1'b1;
    bus.flt_data_out = 16'h9ABC;
    tick();
    checks++;
    if (bus.flt_ack_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_ack: got ack_out=%b, want 1", bus.flt_ack_out);
    end
    tick();
    bus.flt_data_out = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.snk_valid !== 1'b1 || bus.snk_data !== 16'h9ABC || bus.snk_stream !== 2'd1 ||
          bus.flt_ack_out !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h stream=%0d ack_out=%b, want 1 9abc 1 0",
                 i, bus.snk_valid, bus.snk_data, bus.snk_stream, bus.flt_ack_out);
      end
      tick();
    end
    bus.snk_ready = 1'b1;
    tick();
    checks++;
    if (bus.snk_valid !== 1'b0 || bus.flt_ack_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ack_out=%b, want 0 0", bus.snk_valid, bus.flt_ack_out);
    end
    tick();
    checks++;
    if (bus.flt_ack_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_ack: got ack_out=%b, want 1", bus.flt_ack_out);
    end
    bus.flt_req_out = 1'b0;
    bus.snk_ready   = 1'b0;
    tick();
    checks++;
    if (bus.snk_valid !== 1'b1 || bus.snk_data !== 16'hFFFF || bus.snk_stream !== 2'd2) begin
      errors++;
      $display("FAIL bp_second: got valid=%b data=%h stream=%0d, want 1 ffff 2",
               bus.snk_valid, bus.snk_data, bus.snk_stream);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.snk_valid !== 1'b0 || cur_stream !== 2'd0 || underrun_cnt !== 16'd0 ||
        bus.flt_ack_out !== 1'b0 || bus.flt_ack_in !== 1'b0) begin
      errors++;
      $display("FAIL hold_reset: got valid=%b cur=%0d cnt=%h ack_out=%b ack_in=%b, want 0 0 0 0 0",
               bus.snk_valid, cur_stream, underrun_cnt, bus.flt_ack_out, bus.flt_ack_in);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.snk_valid !== 1'b0 || bus.flt_ack_out !== 1'b0 || bus.flt_ack_in !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got valid=%b ack_out=%b ack_in=%b, want 0 0 0",
               bus.snk_valid, bus.flt_ack_out, bus.flt_ack_in);
    end
  endtask

  task automatic test_priority();
    bus.src_valid       = 4'b0011;
    bus.src_data[15:0]  = 16'h1111;
    bus.src_data[31:16] = 16'h2222;
    bus.flt_req_in      = 1'b1;
    bus.flt_req_out     = 1'b1;
    bus.flt_data_out    = 16'h4444;
    bus.snk_ready       = 1'b1;
    tick();
    checks++;
    if (bus.flt_ack_out !== 1'b1 || bus.flt_ack_in !== 1'b0) begin
      errors++;
      $display("FAIL prio_out_wins: got ack_out=%b ack_in=%b, want 1 0", bus.flt_ack_out, bus.flt_ack_in);
    end
    bus.flt_req_out = 1'b0;
    tick();
    checks++;
    if (bus.snk_valid !== 1'b1 || bus.snk_data !== 16'h4444 || bus.snk_stream !== 2'd0 ||
        bus.flt_ack_in !== 1'b0) begin
      errors++;
      $display("FAIL prio_snk: got valid=%b data=%h stream=%0d ack_in=%b, want 1 4444 0 0",
               bus.snk_valid, bus.snk_data, bus.snk_stream, bus.flt_ack_in);
    end
    tick();
    checks++;
    if (bus.snk_valid !== 1'b0 || bus.flt_ack_in !== 1'b0) begin
      errors++;
      $display("FAIL prio_hold_exit: got valid=%b ack_in=%b, want 0 0", bus.snk_valid, bus.flt_ack_in);
    end
    tick();
    checks++;
    if (bus.flt_ack_in !== 1'b1 || bus.flt_data_in !== 16'h2222 || bus.src_ready !== 4'b0010) begin
      errors++;
      $display("FAIL prio_in_after: got ack=%b data=%h ready=%b, want 1 2222 0010",
               bus.flt_ack_in, bus.flt_data_in, bus.src_ready);
    end
    tick();
    tick();
    checks++;
    if (bus.flt_ack_in !== 1'b0 || underrun_cnt !== 16'd0 || cur_stream !== 2'd1) begin
      errors++;
      $display("FAIL pending_blocks_in: got ack_in=%b cnt=%0d cur=%0d, want 0 0 1",
               bus.flt_ack_in, underrun_cnt, cur_stream);
    end
    bus.flt_req_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_input();
    test_output();
    test_wrap();
    test_underrun();
    test_backpressure();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_scheduler.md
Name: stream_scheduler

Overview:
Sequences the multi-stream resampling filter's single input/output req/ack ports against NR_STREAMS independent sample sources and one shared sink. Serves filter input requests from the source of the stream being computed next. Routes each filter result to the sink, tagged with its stream index. Counts input starvation cycles for debug.

Parameters:
DWIDTH, 16, sample width
NR_STREAMS, 4, number of interleaved streams (power of 2)
NR_STREAMS_LOG, 2, log2(NR_STREAMS)
CNT_WIDTH, 16, width of underrun counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
src_valid  in  NR_STREAMS  bit i: source i holds a sample
src_data  in  NR_STREAMS*DWIDTH  slice i (bits i*DWIDTH..i*DWIDTH+DWIDTH-1) = sample of source i
src_ready  out  NR_STREAMS  one-hot pulse: sample of source i consumed this cycle
flt_req_in  in  1  filter requests an input sample
flt_ack_in  out  1  input transfer strobe to filter
flt_data_in  out  DWIDTH  sample to filter, valid while flt_ack_in=1
flt_req_out  in  1  filter offers an output sample
flt_ack_out  out  1  output transfer strobe to filter
flt_data_out  in  DWIDTH  filter result, sampled when flt_ack_out=1
snk_valid  out  1  sink word valid
snk_data  out  DWIDTH  sink word
snk_stream  out  NR_STREAMS_LOG  stream index of sink word
snk_ready  in  1  sink accepts the word when snk_valid=1
cur_stream  out  NR_STREAMS_LOG  stream pointer (next stream to compute)
underrun_cnt  out  CNT_WIDTH  saturating starvation counter

Behaviour:
- Reset: all outputs 0, state IDLE, cur_stream=0, in_pending=0, underrun_cnt=0. Reset mid-transfer aborts it; no strobe is issued in the reset cycle or the cycle after.
- Registered outputs only. A transfer is one cycle with ack=1; each ack is a single-cycle pulse.
- States: IDLE, IN_ACK, OUT_ACK, SNK_HOLD.
- IDLE priority:
  1) in_pending=1: wait for flt_req_out; flt_req_in is ignored.
  2) flt_req_out=1 and snk_valid=0: go to OUT_ACK.
  3) flt_req_in=1 and src_valid[cur_stream]=1: go to IN_ACK.
  4) flt_req_in=1 and src_valid[cur_stream]=0: stay in IDLE, underrun_cnt+1 per cycle, saturating at all-ones.
- IN_ACK (1 cycle):
  - flt_ack_in=1, flt_data_in=src_data slice cur_stream, src_ready[cur_stream]=1; other src_ready bits 0.
  - Sets in_pending=1, returns to IDLE.
  - Latency: flt_req_in seen with source valid -> ack on next cycle.
- OUT_ACK (1 cycle):
  - flt_ack_out=1; captures flt_data_out into snk_data and cur_stream into snk_stream; snk_valid=1 next cycle.
  - Clears in_pending; cur_stream <= cur_stream+1 mod NR_STREAMS; goes to SNK_HOLD.
- SNK_HOLD: holds snk_valid/snk_data/snk_stream stable until snk_ready=1. On that cycle snk_valid drops, next state IDLE. While snk_valid=1, no output ack is issued (backpressure to filter). An input ack may issue from IDLE once SNK_HOLD exits.
- At most one input ack between consecutive output acks. Outputs with no input ack between them are legal (upsampling, L>M).
- Simultaneous flt_req_in and flt_req_out in IDLE with in_pending=0: output wins.
- cur_stream wraps NR_STREAMS-1 -> 0.
- src_valid of non-current streams is never consumed; no reordering.

Test Plan:
- Reset with all inputs 0 -> all outputs 0; cur_stream=0; no ack for 10 cycles.
- flt_req_in=1, src_valid=4'b0001, src_data slice0=16'h1234 -> next cycle flt_ack_in=1, flt_data_in=16'h1234, src_ready=4'b0001, for exactly one cycle.
- After the input, flt_req_out=1, flt_data_out=16'hABCD, snk_ready=1 -> flt_ack_out pulse, then snk_valid=1 with snk_data=16'hABCD, snk_stream=0; cur_stream=1.
- Four outputs, snk_ready always 1 -> snk_stream sequence 0,1,2,3,0 (wrap).
- flt_req_in=1 with src_valid[cur_stream]=0 for 5 cycles -> underrun_cnt=5, no ack; preload the counter to 16'hFFFE and starve 3 cycles -> counter holds 16'hFFFF.
- snk_ready=0 for 8 cycles with flt_req_out held at 1 -> snk_valid and data stable, no second flt_ack_out; snk_ready=1 -> release. Reset asserted in SNK_HOLD -> snk_valid=0 next cycle.
